// File: rtl/game_flow_if.sv
// game_flow_if: key/collision inputs and player-updater control outputs of the game sequencer
// master: front end / player updater side; slave: game_flow_ctrl
interface game_flow_if;
  logic       start, retry, hazard_hit, save_hit;
  logic [9:0] pos_x, pos_y;
  logic [1:0] game_state;
  logic       player_rst, player_en, frame_tick, save_pulse;
  logic [9:0] spawn_x, spawn_y, death_count;
  modport master (
    output start, retry, hazard_hit, save_hit, pos_x, pos_y,
    input  game_state, player_rst, player_en, spawn_x, spawn_y, death_count, frame_tick, save_pulse
  );
  modport slave (
    input  start, retry, hazard_hit, save_hit, pos_x, pos_y,
    output game_state, player_rst, player_en, spawn_x, spawn_y, death_count, frame_tick, save_pulse
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game phase sequencer (title/play/dead/respawn), frame tick, spawn save and death count
// clk, rst (async, active high); g: start/retry/hazard_hit/save_hit/pos_x/pos_y in,
// game_state/player_rst/player_en/spawn_x/spawn_y/death_count/frame_tick/save_pulse out
module game_flow_ctrl #(
  parameter int FRAME_DIV       = 833333,
  parameter int MIN_DEAD_FRAMES = 30,
  parameter int RESPAWN_FRAMES  = 4,
  parameter int INIT_SPAWN_X    = 200,
  parameter int INIT_SPAWN_Y    = 556,
  parameter int MAX_DEATHS      = 999
) (
  input logic        clk,
  input logic        rst,
  game_flow_if.slave g
);
  typedef enum logic [1:0] {TITLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10, RESPAWN = 2'b11} state_t;
  state_t      state, state_n;
  logic [19:0] fdiv, fdiv_n;
  logic [15:0] pf, pf_n;
  logic [9:0]  sx, sy, dc, sx_n, sy_n, dc_n;
  logic        tick, pulse, pulse_n;
  logic        start_q, retry_q, save_q;
  logic        start_r, retry_r, save_r;
  assign start_r = g.start & ~start_q;
  assign retry_r = g.retry & ~retry_q;
  assign save_r  = g.save_hit & ~save_q;
  assign g.game_state  = state;
  assign g.player_rst  = state == TITLE || state == RESPAWN;
  assign g.player_en   = state == PLAY;
  assign g.spawn_x     = sx;
  assign g.spawn_y     = sy;
  assign g.death_count = dc;
  assign g.frame_tick  = tick;
  assign g.save_pulse  = pulse;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= TITLE;
      fdiv    <= '0;
      pf      <= '0;
      sx      <= 10'(INIT_SPAWN_X);
      sy      <= 10'(INIT_SPAWN_Y);
      dc      <= '0;
      tick    <= 1'b0;
      pulse   <= 1'b0;
      start_q <= 1'b1;
      retry_q <= 1'b1;
      save_q  <= 1'b1;
    end else begin
      state   <= state_n;
      fdiv    <= fdiv_n;
      pf      <= pf_n;
      sx      <= sx_n;
      sy      <= sy_n;
      dc      <= dc_n;
      tick    <= fdiv_n == 20'(FRAME_DIV - 1);
      pulse   <= pulse_n;
      start_q <= g.start;
      retry_q <= g.retry;
      save_q  <= g.save_hit;
    end
  always_comb begin
    fdiv_n  = fdiv == 20'(FRAME_DIV - 1) ? '0 : fdiv + 20'd1;
    state_n = state;
    pf_n    = pf;
    sx_n    = sx;
    sy_n    = sy;
    dc_n    = dc;
    pulse_n = 1'b0;
    case (state)
      TITLE:
        if (start_r) begin
          state_n = RESPAWN;
          pf_n    = '0;
          sx_n    = 10'(INIT_SPAWN_X);
          sy_n    = 10'(INIT_SPAWN_Y);
          dc_n    = '0;
        end
      RESPAWN:
        if (tick) begin
          state_n = pf == 16'(RESPAWN_FRAMES - 1) ? PLAY : RESPAWN;
          pf_n    = pf == 16'(RESPAWN_FRAMES - 1) ? '0 : pf + 16'd1;
        end
      PLAY:
        if (g.hazard_hit) begin
          state_n = DEAD;
          pf_n    = '0;
          dc_n    = dc == 10'(MAX_DEATHS) ? dc : dc + 10'd1;
        end else if (retry_r) begin
          state_n = RESPAWN;
          pf_n    = '0;
        end else if (save_r) begin
          sx_n    = g.pos_x;
          sy_n    = g.pos_y;
          pulse_n = 1'b1;
        end
      DEAD: begin
        pf_n = tick && pf != 16'(MIN_DEAD_FRAMES) ? pf + 16'd1 : pf;
        if (retry_r && pf == 16'(MIN_DEAD_FRAMES)) begin
          state_n = RESPAWN;
          pf_n    = '0;
        end
      end
    endcase
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the player datapath. It owns the game phase (title, play, death, respawn) and generates the frame tick. It holds the player state-update block in reset or frozen as the phase requires, and records the save-point spawn position. It counts deaths for the HUD and sits between the key/collision front end and the player state updater.

## Interface

Parameters:
- `FRAME_DIV`, 833333: clk cycles per frame tick (60 Hz at 50 MHz); counter is 20 bits.
- `MIN_DEAD_FRAMES`, 30: frames after death during which `retry` is ignored.
- `RESPAWN_FRAMES`, 4: frames `player_rst` is held during respawn.
- `INIT_SPAWN_X`, 200: initial/title spawn x.
- `INIT_SPAWN_Y`, 556: initial/title spawn y.
- `MAX_DEATHS`, 999: saturation value of `death_count`.

Ports:
- `clk` in 1: system clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start key, level.
- `retry` in 1: retry key, level.
- `hazard_hit` in 1: player overlaps a hazard, level.
- `save_hit` in 1: player overlaps a save point, level.
- `pos_x` in 10: current player x from the state updater.
- `pos_y` in 10: current player y from the state updater.
- `game_state` out 2: phase; 00 TITLE, 01 PLAY, 10 DEAD, 11 RESPAWN.
- `player_rst` out 1: reset to the player state updater.
- `player_en` out 1: 1 lets the updater move the player; 0 freezes it.
- `spawn_x` out 10: position the updater loads on `player_rst`.
- `spawn_y` out 10: position the updater loads on `player_rst`.
- `death_count` out 10: saturating death counter.
- `frame_tick` out 1: one-cycle pulse per frame.
- `save_pulse` out 1: one-cycle pulse when a save is taken (drives save-point flash).

## Operation

- **Frame divider**
  - `fdiv` counts 0..FRAME_DIV-1 and free-runs from reset in every state.
  - `frame_tick` is 1 for the cycle in which `fdiv` is FRAME_DIV-1; `fdiv` wraps to 0 that cycle.
- **Edge detection**
  - `start`, `retry` and `save_hit` are registered; a rise is current=1 and previous=0.
  - The previous registers reset to 1, so a key held through reset produces no edge.
- **TITLE**
  - Outputs: `player_rst`=1, `player_en`=0.
  - A `start` rise loads spawn with INIT_SPAWN_X/Y, clears `death_count`, clears the phase frame counter `pf`, and moves to RESPAWN.
- **RESPAWN**
  - Outputs: `player_rst`=1, `player_en`=0.
  - `pf` increments on each `frame_tick`.
  - When `pf`==RESPAWN_FRAMES-1 and `frame_tick`=1, move to PLAY and clear `pf`.
- **PLAY**
  - Outputs: `player_rst`=0, `player_en`=1. Events are evaluated each cycle with priority hazard > retry > save:
  - `hazard_hit`=1: go to DEAD, clear `pf`, increment `death_count` unless it equals MAX_DEATHS.
  - `retry` rise: go to RESPAWN, clear `pf`; no death is counted.
  - `save_hit` rise: `spawn_x`<=`pos_x`, `spawn_y`<=`pos_y`, `save_pulse`=1 next cycle; stay in PLAY.
- **DEAD**
  - Outputs: `player_rst`=0, `player_en`=0 (the corpse position is held for the overlay).
  - `pf` increments on `frame_tick` and saturates at MIN_DEAD_FRAMES.
  - A `retry` rise while `pf`==MIN_DEAD_FRAMES goes to RESPAWN and clears `pf`; earlier rises are discarded.
  - `hazard_hit` is ignored.
- **Spawn position**
  - Changes only on a TITLE start or a PLAY save.
  - Survives death and retry, but not reset.

## Timing

- **Reset values**
  - `game_state`=00, `player_rst`=1, `player_en`=0.
  - `spawn_x`=INIT_SPAWN_X, `spawn_y`=INIT_SPAWN_Y.
  - `death_count`=0, `frame_tick`=0, `save_pulse`=0.
  - `fdiv`=0, `pf`=0; edge-detect registers reset to 1.
- **Output registering**
  - All outputs are registered; `player_rst`/`player_en` decode from the state register.
  - An input sampled at edge N gives its state change, `death_count` change and `save_pulse` at edge N+1.
  - Edge-detected inputs (`start`, `retry`, `save_hit`) use the registered previous value. A level change seen at edge N is detected at N, so there is one cycle of latency to the output.
- **Simultaneous events**
  - `hazard_hit` with a `save_hit` rise in the same cycle: death wins and spawn is NOT updated.
  - `hazard_hit` with a `retry` rise: death is counted and the state goes to DEAD.
- **Saturation and wrap**
  - `death_count` at MAX_DEATHS stays there on further deaths.
  - `fdiv` wraps; `pf` never wraps (it saturates in DEAD and is cleared on leaving RESPAWN).
- **Reset mid-operation**
  - Asserting `rst` in any state returns to TITLE immediately (asynchronously).
  - A save point taken before reset is lost.
- **Respawn latency**
  - A `frame_tick` in the cycle RESPAWN is entered counts as frame 0.
  - RESPAWN lasts between RESPAWN_FRAMES-1 and RESPAWN_FRAMES frame periods.

## Test plan

Test parameters: FRAME_DIV=4, MIN_DEAD_FRAMES=2, RESPAWN_FRAMES=2 unless noted.

- **Reset/divider:** release `rst` -> `game_state`=00, `player_rst`=1, spawn=(200,556); `frame_tick` pulses every 4th cycle, first at cycle 3 after release.
- **Start/respawn:** `start` 0->1 in TITLE -> `game_state`=11 next edge; `player_rst` stays 1 for 2 frame ticks; then `game_state`=01, `player_rst`=0, `player_en`=1.
- **Save:** in PLAY, `pos`=(321,100), `save_hit` rises -> next edge spawn=(321,100) and `save_pulse` high for exactly 1 cycle. Holding `save_hit` produces no second pulse. `save_hit`+`hazard_hit` together -> spawn unchanged, state DEAD.
- **Death/retry gating:** `hazard_hit` in PLAY -> DEAD, `death_count` 0->1, `player_en`=0. A `retry` rise before 2 frame ticks is ignored; a `retry` rise after -> RESPAWN, then PLAY with spawn retained.
- **Saturation:** MAX_DEATHS=3, four deaths -> `death_count` reads 1,2,3,3.
- **Async reset:** assert `rst` mid-DEAD with spawn=(321,100) -> outputs reach reset values without a clock edge, spawn=(200,556); `start` held through reset release -> stays TITLE until it is released and pressed again.
